// File: rtl/overlay_decoder.sv
// Inverse of the overlay colouring stage: classifies RGB pixels and
// accumulates per-frame symbol statistics into a handshaked report.
module overlay_decoder #(
  parameter int CNT_W = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             in_sof,
  input  logic             in_eof,
  input  logic [7:0]       r_in,
  input  logic [7:0]       g_in,
  input  logic [7:0]       b_in,
  output logic             pix_valid,
  output logic [2:0]       pix_class,
  output logic [5:0]       pix_data,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] rpt_cnt0,
  output logic [CNT_W-1:0] rpt_cnt1,
  output logic [CNT_W-1:0] rpt_cnt2,
  output logic [CNT_W-1:0] rpt_cnt3,
  output logic [CNT_W-1:0] rpt_cnt_pass,
  output logic [CNT_W-1:0] rpt_cnt_err,
  output logic [2:0]       rpt_dominant,
  output logic             frame_abort,
  output logic             rpt_overrun
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] ACCUM = 1'b1;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic [23:0] rgb;
  logic [2:0]  cls;
  logic [5:0]  dat;

  logic [0:0] state_q, state_d;
  logic [5:0][CNT_W-1:0] acc_q, acc_d;
  logic       cnt_en, issue;
  logic [2:0] dom;
  logic [CNT_W-1:0] best;

  logic       pix_valid_q, pix_valid_d;
  logic [2:0] pix_class_q, pix_class_d;
  logic [5:0] pix_data_q, pix_data_d;

  logic       rpt_valid_q, rpt_valid_d;
  logic [5:0][CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic [2:0] rpt_dom_q, rpt_dom_d;
  logic       xfer;

  logic abort_q, abort_d;
  logic ovr_q, ovr_d;

  assign rgb = {r_in, g_in, b_in};

  always_comb begin
    cls = 3'd5;
    dat = 6'd0;
    unique case (1'b1)
      (rgb == 24'hFFFF00): cls = 3'd0;
      (rgb == 24'h00FF00): cls = 3'd1;
      (rgb == 24'h0000FF): cls = 3'd2;
      (rgb == 24'hFF0000): cls = 3'd3;
      (r_in == g_in && g_in == b_in && r_in[7:6] == 2'b11): begin
        cls = 3'd4;
        dat = r_in[5:0];
      end
      default: cls = 3'd5;
    endcase
  end

  // A pixel counts when it opens a frame or arrives inside one
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_en  = 1'b0;
    issue   = 1'b0;
    abort_d = 1'b0;
    if (in_valid) begin
      cnt_en = in_sof || (state_q == ACCUM);
      if (in_sof) begin
        acc_d   = '0;
        abort_d = (state_q == ACCUM);
      end
      if (cnt_en && acc_d[cls] != CMAX) begin
        acc_d[cls] = acc_d[cls] + 1'b1;
      end
      if (cnt_en && in_eof) begin
        issue   = 1'b1;
        state_d = IDLE;
      end else if (cnt_en) begin
        state_d = ACCUM;
      end
    end
  end

  // Strict > keeps the lowest index on ties
  always_comb begin
    dom  = 3'd0;
    best = acc_d[0];
    for (int i = 1; i < 4; i++) begin
      if (acc_d[i] > best) begin
        best = acc_d[i];
        dom  = 3'(i);
      end
    end
    if (best == '0) dom = 3'd4;
  end

  always_comb begin
    xfer        = rpt_valid_q && rpt_ready;
    rpt_valid_d = rpt_valid_q && !xfer;
    rpt_cnt_d   = rpt_cnt_q;
    rpt_dom_d   = rpt_dom_q;
    ovr_d       = 1'b0;
    if (issue) begin
      if (rpt_valid_q && !xfer) begin
        ovr_d = 1'b1;
      end else begin
        rpt_valid_d = 1'b1;
        rpt_cnt_d   = acc_d;
        rpt_dom_d   = dom;
      end
    end
  end

  always_comb begin
    pix_valid_d = in_valid;
    pix_class_d = in_valid ? cls : 3'd0;
    pix_data_d  = (in_valid && cls == 3'd4) ? dat : 6'd0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      pix_valid_q <= 1'b0;
      pix_class_q <= 3'd0;
      pix_data_q  <= 6'd0;
      rpt_valid_q <= 1'b0;
      rpt_cnt_q   <= '0;
      rpt_dom_q   <= 3'd0;
      abort_q     <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      pix_valid_q <= pix_valid_d;
      pix_class_q <= pix_class_d;
      pix_data_q  <= pix_data_d;
      rpt_valid_q <= rpt_valid_d;
      rpt_cnt_q   <= rpt_cnt_d;
      rpt_dom_q   <= rpt_dom_d;
      abort_q     <= abort_d;
      ovr_q       <= ovr_d;
    end
  end

  assign pix_valid    = pix_valid_q;
  assign pix_class    = pix_class_q;
  assign pix_data     = pix_data_q;
  assign rpt_valid    = rpt_valid_q;
  assign rpt_cnt0     = rpt_cnt_q[0];
  assign rpt_cnt1     = rpt_cnt_q[1];
  assign rpt_cnt2     = rpt_cnt_q[2];
  assign rpt_cnt3     = rpt_cnt_q[3];
  assign rpt_cnt_pass = rpt_cnt_q[4];
  assign rpt_cnt_err  = rpt_cnt_q[5];
  assign rpt_dominant = rpt_dom_q;
  assign frame_abort  = abort_q;
  assign rpt_overrun  = ovr_q;

endmodule
